pc_fetch_unit: RTL and testbench

- Program counter and instruction-fetch stage that consumes the branch unit's NextPCSrc decision together with the computed branch target.
- Keeps the PC and issues word fetches to instruction memory over a request/grant/response handshake, with at most one request outstanding.
- Fetched instructions and their PCs go into a small FIFO feeding decode over a valid/ready handshake.
- On a taken branch it flushes wrong-path instructions and discards any in-flight response.

---
 rtl/pc_fetch_unit_if.sv | 25 ++
 rtl/pc_fetch_unit.sv | 116 +++++++++++
 tb/tb_pc_fetch_unit.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: instruction-memory and decode handshake bundle for the fetch stage
// imem_req/imem_addr   fetch request and word address (fetch unit drives)
// imem_gnt             request accepted this cycle
// imem_rvalid/rdata    response valid and instruction word
// if_valid/inst/pc     FIFO head presented to decode (fetch unit drives)
// if_ready             decode accepts the head
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_ready;
  modport master (
    output imem_req, imem_addr, if_valid, if_inst, if_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, if_ready
  );
  modport slave (
    input  imem_req, imem_addr, if_valid, if_inst, if_pc,
    output imem_gnt, imem_rvalid, imem_rdata, if_ready
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter, single-outstanding instruction fetch and decode FIFO
// clk, rst         clock; asynchronous active-high reset
// ex_valid         branch-unit instruction valid (qualifies NextPCSrc)
// NextPCSrc        1 = redirect to BrTarget
// BrTarget         branch/jump target
// misalign         one-cycle pulse on a misaligned redirect (only with MISALIGN_TRAP_EN)
// bus              pc_fetch_unit_if.master: imem request/grant/response and decode valid/ready
// Optional feature macro: MISALIGN_TRAP_EN (redirect misaligned targets to TRAP_VEC)
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        NextPCSrc,
  input  logic [31:0] BrTarget,
  output logic        misalign,
  pc_fetch_unit_if.master bus
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(BUF_DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t      state_q;
  logic [31:0] pc_q, req_pc_q, new_pc;
  logic        req_q, drop_q;
  logic [31:0] inst_q [BUF_DEPTH];
  logic [31:0] ipc_q [BUF_DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0] cnt_q, cnt_d;
  logic        redirect, valid, push, pop, space;
`ifdef MISALIGN_TRAP_EN
  logic        mis_q;
  assign new_pc   = |BrTarget[1:0] ? TRAP_VEC : {BrTarget[31:2], 2'b00};
  assign misalign = mis_q;
`else
  logic        unused_trap;
  assign new_pc      = {BrTarget[31:2], 2'b00};
  assign misalign    = 1'b0;
  assign unused_trap = ^{TRAP_VEC, BrTarget[1:0]};
`endif
  assign redirect = ex_valid & NextPCSrc;
  assign valid    = cnt_q != '0;
  assign pop      = valid & bus.if_ready;
  // a response is stored only if it is neither marked stale nor overtaken by a redirect
  assign push     = (state_q == WAIT) & bus.imem_rvalid & ~drop_q & ~redirect;
  assign cnt_d    = redirect ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  // a new request is allowed only when a slot is free for its response after this edge
  assign space    = cnt_d < DEPTH;
  assign bus.imem_req  = req_q;
  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = valid;
  assign bus.if_inst   = inst_q[rd_q];
  assign bus.if_pc     = ipc_q[rd_q];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      req_q    <= 1'b0;
      drop_q   <= 1'b0;
      rd_q     <= '0;
      wr_q     <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        inst_q[i] <= '0;
        ipc_q[i]  <= '0;
      end
`ifdef MISALIGN_TRAP_EN
      mis_q    <= 1'b0;
`endif
    end else begin
`ifdef MISALIGN_TRAP_EN
      mis_q <= redirect & (|BrTarget[1:0]);
`endif
      if (redirect) begin
        rd_q <= '0;
        wr_q <= '0;
      end else begin
        if (push) begin
          inst_q[wr_q] <= bus.imem_rdata;
          ipc_q[wr_q]  <= req_pc_q;
          wr_q         <= wr_q + AW'(1);
        end
        if (pop) rd_q <= rd_q + AW'(1);
      end
      cnt_q <= cnt_d;
      pc_q  <= redirect ? new_pc : (state_q == REQ && bus.imem_gnt) ? pc_q + 32'd4 : pc_q;
      case (state_q)
        IDLE: begin
          state_q <= space ? REQ : IDLE;
          req_q   <= space;
        end
        REQ: if (bus.imem_gnt) begin
          // a grant coinciding with a redirect still owes a response, which must be thrown away
          req_pc_q <= pc_q;
          drop_q   <= redirect;
          state_q  <= WAIT;
          req_q    <= 1'b0;
        end
        WAIT: if (bus.imem_rvalid) begin
          drop_q  <= 1'b0;
          state_q <= space ? REQ : IDLE;
          req_q   <= space;
        end else begin
          drop_q  <= drop_q | redirect;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed bench with a program-order fetch model and memory stub for pc_fetch_unit
module tb_pc_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0004;
`ifdef MISALIGN_TRAP_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        NextPCSrc = 1'b0;
  logic [31:0] BrTarget = '0;
  logic        misalign;
  pc_fetch_unit_if bus();
  pc_fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(2), .TRAP_VEC(TRAP_VEC)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .NextPCSrc(NextPCSrc),
    .BrTarget(BrTarget), .misalign(misalign), .bus(bus)
  );
  always #5 clk = ~clk;
  int errors = 0;
  int checks = 0;
  int rdelay = 1;
  int gcnt = 0;
  int pcnt = 0;
  bit pending = 1'b0;
  bit was_pending;
  bit prev_hold = 1'b0;
  bit prev_redir = 1'b0;
  logic        redir, exp_mis;
  logic [31:0] paddr, tgt, exp_pc, exp_fetch, prev_addr;
  logic [31:0] pops_pc[$];
  logic [31:0] pops_inst[$];
  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", n, act, exp);
    end
  endtask
  // memory stub plus program-order model; inputs driven and outputs checked on the falling edge
  initial begin
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0;
    exp_pc = RESET_PC;
    exp_fetch = RESET_PC;
    exp_mis = 1'b0;
    forever begin
      @(negedge clk);
      was_pending = pending;
      bus.imem_rvalid = 1'b0;
      if (pending) begin
        if (pcnt <= 1) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata = word(paddr);
          pending = 1'b0;
        end else pcnt--;
      end
      bus.imem_gnt = bus.imem_req & ~was_pending;
      if (bus.imem_gnt) begin
        pending = 1'b1;
        pcnt = rdelay;
        paddr = bus.imem_addr;
        gcnt++;
      end
      if (rst) begin
        chk("rst_req", bus.imem_req, 0);
        chk("rst_addr", bus.imem_addr, RESET_PC);
        chk("rst_valid", bus.if_valid, 0);
        chk("rst_inst", bus.if_inst, 0);
        chk("rst_pc", bus.if_pc, 0);
        chk("rst_misalign", misalign, 0);
        exp_pc = RESET_PC;
        exp_fetch = RESET_PC;
        exp_mis = 1'b0;
        prev_hold = 1'b0;
        prev_redir = 1'b0;
      end else begin
        chk("misalign", misalign, exp_mis);
        if (prev_redir) chk("flush_valid", bus.if_valid, 0);
        if (prev_hold) begin
          chk("req_hold", bus.imem_req, 1);
          chk("addr_hold", bus.imem_addr, prev_addr);
        end
        redir = ex_valid & NextPCSrc;
`ifdef MISALIGN_TRAP_EN
        tgt = (BrTarget[1:0] != 2'b00) ? TRAP_VEC : {BrTarget[31:2], 2'b00};
        exp_mis = redir & (BrTarget[1:0] != 2'b00);
`else
        tgt = {BrTarget[31:2], 2'b00};
        exp_mis = 1'b0;
`endif
        if (bus.imem_gnt) begin
          chk("fetch_addr", bus.imem_addr, exp_fetch);
          exp_fetch += 32'd4;
        end
        if (redir) begin
          exp_fetch = tgt;
          exp_pc = tgt;
        end else if (bus.if_valid & bus.if_ready) begin
          chk("pop_pc", bus.if_pc, exp_pc);
          chk("pop_inst", bus.if_inst, word(exp_pc));
          pops_pc.push_back(bus.if_pc);
          pops_inst.push_back(bus.if_inst);
          exp_pc += 32'd4;
        end
        prev_redir = redir;
        prev_hold = bus.imem_req & ~bus.imem_gnt & ~redir;
        prev_addr = bus.imem_addr;
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_pops(input int n);
    int t = 0;
    while (pops_pc.size() < n && t < 200) begin
      cyc();
      t++;
    end
    chk("pops_seen", pops_pc.size() >= n, 1);
  endtask
  task automatic wait_grant();
    int g = gcnt;
    int t = 0;
    while (gcnt == g && t < 100) begin
      cyc();
      t++;
    end
    chk("grant_seen", gcnt != g, 1);
  endtask
  task automatic do_reset();
    cyc();
    rst = 1'b1;
    pops_pc.delete();
    pops_inst.delete();
    repeat (2) cyc();
    rst = 1'b0;
  endtask
  task automatic branch(input logic ev, input logic [31:0] t);
    ex_valid = ev;
    NextPCSrc = 1'b1;
    BrTarget = t;
    cyc();
    ex_valid = 1'b0;
    NextPCSrc = 1'b0;
  endtask
  initial begin
    int lat, g0, n0, n4, t;
    bit found;
    bus.if_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    lat = 0;
    while (!bus.if_valid && lat < 20) begin
      cyc();
      lat++;
    end
    chk("first_latency", lat >= 2 && lat <= 4, 1);
    wait_pops(4);
    chk("seq_pc0", pops_pc[0], 32'h0);
    chk("seq_pc1", pops_pc[1], 32'h4);
    chk("seq_pc2", pops_pc[2], 32'h8);
    chk("seq_pc3", pops_pc[3], 32'hC);
    chk("seq_inst0", pops_inst[0], 32'hA5A5_0000);
    chk("seq_inst3", pops_inst[3], 32'hA5A5_000C);
    bus.if_ready = 1'b0;
    do_reset();
    g0 = gcnt;
    repeat (12) cyc();
    chk("stall_req", bus.imem_req, 0);
    chk("stall_valid", bus.if_valid, 1);
    chk("stall_head_pc", bus.if_pc, 32'h0);
    chk("stall_head_inst", bus.if_inst, 32'hA5A5_0000);
    chk("stall_fetches", gcnt - g0, 2);
    bus.if_ready = 1'b1;
    wait_pops(3);
    chk("stall_pop0", pops_pc[0], 32'h0);
    chk("stall_pop1", pops_pc[1], 32'h4);
    chk("stall_pop2", pops_pc[2], 32'h8);
    rdelay = 3;
    wait_grant();
    n0 = pops_pc.size();
    branch(1'b1, 32'h100);
    rdelay = 1;
    wait_pops(n0 + 1);
    chk("wait_redir_pc", pops_pc[n0], 32'h100);
    chk("wait_redir_inst", pops_inst[n0], 32'hA5A5_0100);
    bus.if_ready = 1'b0;
    found = 1'b0;
    t = 0;
    g0 = gcnt;
    while (!found && t < 100) begin
      cyc();
      found = (gcnt != g0) && bus.if_valid;
      g0 = gcnt;
      t++;
    end
    chk("full_setup", found, 1);
    bus.if_ready = 1'b1;
    n4 = pops_pc.size();
    branch(1'b1, 32'h200);
    chk("full_flush_valid", bus.if_valid, 0);
    wait_pops(n4 + 1);
    chk("full_redir_pc", pops_pc[n4], 32'h200);
    n0 = pops_pc.size();
    NextPCSrc = 1'b1;
    BrTarget = 32'h300;
    repeat (6) cyc();
    NextPCSrc = 1'b0;
    wait_pops(n0 + 2);
    chk("no_flush_pc", pops_pc[n0 + 1], 32'h200 + 32'(4 * (n0 + 1 - n4)));
    n0 = pops_pc.size();
    branch(1'b1, 32'h102);
    chk("misalign_pulse", misalign, MIS);
    cyc();
    chk("misalign_end", misalign, 0);
    wait_pops(n0 + 1);
    chk("misalign_target", pops_pc[n0], MIS ? 32'h4 : 32'h100);
    rdelay = 3;
    wait_grant();
    rst = 1'b1;
    pops_pc.delete();
    pops_inst.delete();
    #1;
    chk("async_req", bus.imem_req, 0);
    chk("async_valid", bus.if_valid, 0);
    chk("async_addr", bus.imem_addr, RESET_PC);
    cyc();
    rst = 1'b0;
    rdelay = 1;
    wait_pops(2);
    chk("rst_restart_pc0", pops_pc[0], 32'h0);
    chk("rst_restart_inst0", pops_inst[0], 32'hA5A5_0000);
    chk("rst_restart_pc1", pops_pc[1], 32'h4);
    repeat (4) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end
endmodule
